mips_dbg_scanner: RTL and testbench
===================================

// Module: mips_dbg_scanner
// PURPOSE
// - Reader side of the MIPS top's debug readout port (sw_addr in; data/pc/state out).
// - Sweeps sw_addr over an address window and waits for the readout to settle.
// - Captures each 32-bit word and streams it as framed bytes over a valid/ready byte
//   interface, ready for a UART TX or trace FIFO.
// - Sits beside the MIPS top on the board, in place of the manual switches.
// PARAMETERS
// - ADDR_W      7    width of sw_addr
// - FIRST_ADDR  0    first address scanned
// - LAST_ADDR   127  last address scanned (FIRST_ADDR <= LAST_ADDR < 2**ADDR_W)
// - SETTLE_CYC  2    cycles sw_addr is held before data is sampled (>=1)
// PORTS
// - clk       in   1       system clock, all logic rising-edge
// - rst       in   1       asynchronous, active-low reset
// - start     in   1       begin a scan; sampled only in IDLE
// - abort     in   1       stop the scan at the next safe point (see BEHAVIOUR)
// - sw_addr   out  ADDR_W  address driven to the MIPS debug port
// - data      in   32      word returned for sw_addr
// - pc        in   32      MIPS program counter
// - state     in   4       MIPS control-unit state
// - tx_valid  out  1       tx_byte holds a valid byte
// - tx_ready  in   1       sink accepts the byte; transfer when tx_valid&&tx_ready
// - tx_byte   out  8       byte stream, MSB-first within each word
// - busy      out  1       high from leaving IDLE until back in IDLE
// - done      out  1       one-cycle pulse when a scan completes or aborts
// BEHAVIOUR
// - Reset values (async, rst=0):
//   - state IDLE; sw_addr=FIRST_ADDR; tx_valid=0; tx_byte=0; busy=0; done=0.
//   - Capture registers and counters are cleared.
//   - Reset mid-frame drops the frame immediately; no handshake is honoured.
// - FSM: IDLE -> SETTLE -> CAPTURE -> SEND -> (SETTLE | FINISH) -> IDLE.
// - IDLE: start=1 -> SETTLE next cycle with sw_addr=FIRST_ADDR and busy=1.
//   - start while busy is ignored.
// - SETTLE: hold sw_addr for exactly SETTLE_CYC cycles, then go to CAPTURE.
// - CAPTURE (1 cycle): register data into the shadow word, then go to SEND.
//   - Later changes on data do not affect the frame being sent.
// - SEND: frame = {1'b0,sw_addr zero-extended to 7b}, data[31:24], [23:16], [15:8], [7:0].
//   - tx_valid is registered. tx_byte and tx_valid are stable until accepted.
//   - The next byte is presented in the cycle after a transfer (1 byte / 2 cycles max).
//   - tx_valid never drops without a transfer.
// - After the last byte of a frame:
//   - sw_addr==LAST_ADDR -> FINISH.
//   - Otherwise sw_addr+1 -> SETTLE.
//   - No wrap past LAST_ADDR. FIRST_ADDR==LAST_ADDR gives a single frame.
// - FINISH (1 cycle): done=1, busy drops to 0 the next cycle, sw_addr kept until the next start.
// - abort:
//   - Sticky once seen while busy.
//   - Taken in SETTLE/CAPTURE at once, or in SEND only after the current byte transfers.
//     The rest of the frame is discarded.
//   - Then FINISH (done pulses). abort in IDLE has no effect.
// - start and abort in the same IDLE cycle: start wins, and the abort is not stored.
// CONFIGURATION
// - DBG_PC_TAG_EN defined:
//   - pc and state are captured in CAPTURE together with data.
//   - Each frame gets 5 more bytes: pc[31:24..7:0], then {4'h0,state}. Frame is 10 bytes.
// - Not defined: 5-byte frames; pc and state are unused and carry no logic.
// TESTING
// - Reset in IDLE -> all outputs at reset values.
//   start with FIRST=0, LAST=2, data=addr*0x11111111, tx_ready=1 -> bytes
//   00 00 00 00 00, 01 11 11 11 11, 02 22 22 22 22; single done pulse; busy low after.
// - Backpressure: tx_ready toggling with random stalls up to 5 cycles ->
//   identical byte sequence; tx_byte stable whenever tx_valid=1 && tx_ready=0.
// - Settle: data changes 1 cycle after each sw_addr change (SETTLE_CYC=2) ->
//   captured value is the new one; data changing during SEND -> frame unchanged.
// - abort asserted during byte 3 of frame 1 with tx_ready=0 ->
//   byte 3 still transfers once tx_ready=1, no further bytes, done=1, then IDLE.
// - rst pulled low mid-SEND -> tx_valid=0 and busy=0 asynchronously;
//   new start gives a clean frame from FIRST_ADDR.
// - DBG_PC_TAG_EN with pc=0x00400010, state=4'h7 -> each frame ends
//   00 40 00 10 07 (10 bytes); without it, 5 bytes per frame.

Source files
------------

// File: rtl/mips_dbg_scanner.sv
// -----------------------------------------------------------------------------
// mips_dbg_scanner
//
// Purpose:
//   Reads the MIPS top's debug readout port in place of the board switches.
//   It sweeps sw_addr from FIRST_ADDR to LAST_ADDR. For each address it holds
//   sw_addr for SETTLE_CYC cycles, then captures the returned 32-bit word, then
//   streams that word as a framed byte sequence over a valid/ready byte port
//   that feeds a UART TX or a trace FIFO.
//
//   Frame (default build, 5 bytes):
//     {1'b0, sw_addr[6:0]}, data[31:24], data[23:16], data[15:8], data[7:0]
//   Frame with DBG_PC_TAG_EN defined (10 bytes), appended after the above:
//     pc[31:24], pc[23:16], pc[15:8], pc[7:0], {4'h0, state}
//
// Configuration macro:
//   DBG_PC_TAG_EN - when defined, pc and state are captured along with data
//                   and appended to every frame. When undefined, pc and state
//                   are not used.
//
// Ports:
//   clk        in   1       system clock, rising edge
//   rst        in   1       asynchronous reset, active low
//   start      in   1       begin a scan (sampled only while idle)
//   abort      in   1       stop the scan at the next safe point
//   sw_addr    out  ADDR_W  address driven to the MIPS debug port
//   data       in   32      word returned for sw_addr
//   pc         in   32      MIPS program counter (frame tag only)
//   state      in   4       MIPS control-unit state (frame tag only)
//   tx_valid   out  1       tx_byte holds a valid byte
//   tx_ready   in   1       sink accepts the byte
//   tx_byte    out  8       byte stream, MSB-first within each word
//   busy       out  1       high from leaving IDLE until back in IDLE
//   done       out  1       one-cycle pulse when a scan completes or aborts
//   scan_state out  3       current scanner FSM state, for debug visibility
//
// Handshake:
//   A byte moves on every rising edge where tx_valid && tx_ready. Once
//   tx_valid is raised, tx_valid and tx_byte hold until that transfer. After a
//   transfer, tx_valid drops for one cycle and the next byte follows, so the
//   stream runs at most one byte every two cycles.
// -----------------------------------------------------------------------------
module mips_dbg_scanner #(
    parameter int ADDR_W     = 7,
    parameter int FIRST_ADDR = 0,
    parameter int LAST_ADDR  = 127,
    parameter int SETTLE_CYC = 2     // 1..256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] sw_addr,
    input  logic [31:0]       data,
    input  logic [31:0]       pc,
    input  logic [3:0]        state,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [7:0]        tx_byte,
    output logic              busy,
    output logic              done,
    output logic [2:0]        scan_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_CAPTURE = 3'd2,
        S_SEND    = 3'd3,
        S_FINISH  = 3'd4
    } scan_state_e;

`ifdef DBG_PC_TAG_EN
    localparam int FRAME_BYTES = 10;
`else
    localparam int FRAME_BYTES = 5;
`endif

    localparam logic [3:0]        LAST_BYTE   = 4'(FRAME_BYTES - 1);
    localparam logic [7:0]        SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [ADDR_W-1:0] FIRST_A     = ADDR_W'(FIRST_ADDR);
    localparam logic [ADDR_W-1:0] LAST_A      = ADDR_W'(LAST_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_ONE    = ADDR_W'(1);

    scan_state_e fsm;
    logic [7:0]  settle_cnt;
    logic [3:0]  byte_idx;      // index of the byte currently or next presented
    logic [31:0] shadow_data;
    logic        abort_pend;    // abort seen earlier in this scan
    logic        abort_now;
    logic [7:0]  next_byte;
    logic [7:0]  header_byte;

`ifdef DBG_PC_TAG_EN
    logic [31:0] shadow_pc;
    logic [3:0]  shadow_state;
`else
    // pc and state feed nothing in this build; this reduction is left dangling.
    logic unused_tag;
    assign unused_tag = ^{pc, state};
`endif

    assign scan_state  = fsm;
    assign abort_now   = abort_pend | abort;
    // Address field is always 7 bits wide, zero-extended or truncated from sw_addr.
    assign header_byte = {1'b0, 7'(sw_addr)};

    // Payload byte selected by byte_idx; index 0 (the header) is loaded
    // directly at the end of CAPTURE.
    always_comb begin
        next_byte = 8'h00;
        case (byte_idx)
            4'd1:    next_byte = shadow_data[31:24];
            4'd2:    next_byte = shadow_data[23:16];
            4'd3:    next_byte = shadow_data[15:8];
            4'd4:    next_byte = shadow_data[7:0];
`ifdef DBG_PC_TAG_EN
            4'd5:    next_byte = shadow_pc[31:24];
            4'd6:    next_byte = shadow_pc[23:16];
            4'd7:    next_byte = shadow_pc[15:8];
            4'd8:    next_byte = shadow_pc[7:0];
            4'd9:    next_byte = {4'h0, shadow_state};
`endif
            default: next_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm         <= S_IDLE;
            sw_addr     <= FIRST_A;
            settle_cnt  <= 8'd0;
            byte_idx    <= 4'd0;
            shadow_data <= 32'd0;
`ifdef DBG_PC_TAG_EN
            shadow_pc    <= 32'd0;
            shadow_state <= 4'd0;
`endif
            abort_pend  <= 1'b0;
            tx_valid    <= 1'b0;
            tx_byte     <= 8'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            // done is high only during the FINISH cycle.
            done <= 1'b0;

            case (fsm)
                S_IDLE: begin
                    // An abort arriving with start is ignored.
                    if (start) begin
                        fsm        <= S_SETTLE;
                        sw_addr    <= FIRST_A;
                        settle_cnt <= 8'd0;
                        abort_pend <= 1'b0;
                        busy       <= 1'b1;
                    end
                end

                S_SETTLE: begin
                    if (abort_now) begin
                        fsm  <= S_FINISH;
                        done <= 1'b1;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        fsm        <= S_CAPTURE;
                        settle_cnt <= 8'd0;
                    end else begin
                        settle_cnt <= settle_cnt + 8'd1;
                    end
                end

                S_CAPTURE: begin
                    if (abort_now) begin
                        fsm  <= S_FINISH;
                        done <= 1'b1;
                    end else begin
                        shadow_data <= data;
`ifdef DBG_PC_TAG_EN
                        shadow_pc    <= pc;
                        shadow_state <= state;
`endif
                        byte_idx <= 4'd0;
                        tx_byte  <= header_byte;
                        tx_valid <= 1'b1;
                        fsm      <= S_SEND;
                    end
                end

                S_SEND: begin
                    if (abort) begin
                        abort_pend <= 1'b1;
                    end
                    if (tx_valid) begin
                        // A presented byte is never withdrawn; abort waits for it.
                        if (tx_ready) begin
                            tx_valid <= 1'b0;
                            if (abort_now) begin
                                fsm  <= S_FINISH;
                                done <= 1'b1;
                            end else if (byte_idx == LAST_BYTE) begin
                                if (sw_addr == LAST_A) begin
                                    fsm  <= S_FINISH;
                                    done <= 1'b1;
                                end else begin
                                    sw_addr    <= sw_addr + ADDR_ONE;
                                    settle_cnt <= 8'd0;
                                    fsm        <= S_SETTLE;
                                end
                            end else begin
                                byte_idx <= byte_idx + 4'd1;
                            end
                        end
                    end else begin
                        // Gap cycle after a transfer: nothing is outstanding.
                        if (abort_now) begin
                            fsm  <= S_FINISH;
                            done <= 1'b1;
                        end else begin
                            tx_byte  <= next_byte;
                            tx_valid <= 1'b1;
                        end
                    end
                end

                S_FINISH: begin
                    fsm        <= S_IDLE;
                    busy       <= 1'b0;
                    abort_pend <= 1'b0;
                end

                default: begin
                    fsm      <= S_IDLE;
                    busy     <= 1'b0;
                    tx_valid <= 1'b0;
                end
            endcase

            // abort is sticky anywhere within a scan; FINISH clears it.
            if (abort && (fsm == S_SETTLE || fsm == S_CAPTURE)) begin
                abort_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mips_dbg_scanner.sv
// -----------------------------------------------------------------------------
// tb_mips_dbg_scanner
//
// Drives mips_dbg_scanner (FIRST_ADDR=0, LAST_ADDR=2, SETTLE_CYC=2) through a
// linear sequence of directed steps. The MIPS debug port is modelled as
// data = sw_addr * 32'h11111111 with one cycle of latency, and data is forced
// to garbage while the scanner is sending so any late sampling shows up.
// -----------------------------------------------------------------------------
module tb_mips_dbg_scanner;

    localparam int ADDR_W = 7;

    logic              clk;
    logic              rst;
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] sw_addr;
    logic [31:0]       data;
    logic [31:0]       pc;
    logic [3:0]        mips_state;
    logic              tx_valid;
    logic              tx_ready;
    logic [7:0]        tx_byte;
    logic              busy;
    logic              done;
    logic [2:0]        scan_state;

    logic [31:0] data_q;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    int n_tests;
    int n_fail;
    int done_cnt;
    int done_base;
    int got_base;
    bit hold;
    logic [7:0] hold_byte;

    mips_dbg_scanner #(
        .ADDR_W    (ADDR_W),
        .FIRST_ADDR(0),
        .LAST_ADDR (2),
        .SETTLE_CYC(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .sw_addr   (sw_addr),
        .data      (data),
        .pc        (pc),
        .state     (mips_state),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_byte   (tx_byte),
        .busy      (busy),
        .done      (done),
        .scan_state(scan_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- MIPS debug port model ----------------
    always @(posedge clk) data_q <= 32'(sw_addr) * 32'h1111_1111;
    assign data = (scan_state == 3'd3) ? 32'hDEAD_BEEF : data_q;

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // One clock: sample outputs at negedge (collect bytes, count done, check
    // hold stability), then return just after the next rising edge.
    task automatic tick();
        @(negedge clk);
        if (!rst) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                check("hold_valid", 32'(tx_valid), 32'd1);
                check("hold_byte", 32'(tx_byte), 32'(hold_byte));
            end
            hold      = tx_valid && !tx_ready;
            hold_byte = tx_byte;
            if (tx_valid && tx_ready) got_q.push_back(tx_byte);
            if (done) done_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input int a, input int nbytes);
        logic [31:0] w;
        logic [7:0]  fr[$];
        w = 32'(a) * 32'h1111_1111;
        fr.push_back(8'(a));
        fr.push_back(w[31:24]);
        fr.push_back(w[23:16]);
        fr.push_back(w[15:8]);
        fr.push_back(w[7:0]);
`ifdef DBG_PC_TAG_EN
        fr.push_back(8'h00);
        fr.push_back(8'h40);
        fr.push_back(8'h00);
        fr.push_back(8'h10);
        fr.push_back(8'h07);
`endif
        for (int i = 0; i < nbytes && i < fr.size(); i++) exp_q.push_back(fr[i]);
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_len"}, 32'(got_q.size() - got_base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (got_base + i < got_q.size()) check(tag, 32'(got_q[got_base + i]), 32'(exp_q[i]));
        end
        exp_q.delete();
    endtask

    task automatic launch();
        done_base = done_cnt;
        got_base  = got_q.size();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Run until the scan has pulsed done and returned to idle (bounded).
    task automatic run_scan(input bit rnd, input bit poke);
        int stall;
        bit fin;
        stall = 0;
        fin   = 1'b0;
        for (int c = 0; c < 3000 && !fin; c++) begin
            if (rnd) begin
                if (stall > 0) begin
                    tx_ready = 1'b0;
                    stall--;
                end else begin
                    tx_ready = 1'b1;
                    if ($urandom_range(0, 2) == 0) stall = $urandom_range(1, 5);
                end
            end
            start = poke && (c == 9);
            tick();
            if (!busy && done_cnt != done_base) fin = 1'b1;
        end
        start = 1'b0;
        check("scan_finished", 32'(fin), 32'd1);
        check("done_pulses", 32'(done_cnt - done_base), 32'd1);
        check("done_low_idle", 32'(done), 32'd0);
    endtask

    task automatic expect_full_scan();
        push_frame(0, 10);
        push_frame(1, 10);
        push_frame(2, 10);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit ok;
        n_tests   = 0;
        n_fail    = 0;
        done_cnt  = 0;
        done_base = 0;
        got_base  = 0;
        hold      = 1'b0;
        hold_byte = 8'h00;
        rst        = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        tx_ready   = 1'b0;
        pc         = 32'h0040_0010;
        mips_state = 4'h7;

        // Step 1: reset values.
        repeat (3) @(posedge clk);
        #1;
        check("rst_sw_addr", 32'(sw_addr), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_byte", 32'(tx_byte), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_fsm", 32'(scan_state), 32'd0);
        rst = 1'b1;
        tick();

        // Step 2: plain scan, sink always ready.
        tx_ready = 1'b1;
        launch();
        check("busy_after_start", 32'(busy), 32'd1);
        check("addr_after_start", 32'(sw_addr), 32'd0);
        run_scan(1'b0, 1'b0);
        expect_full_scan();
        compare_stream("plain");
        check("plain_busy_low", 32'(busy), 32'd0);
        check("plain_addr_kept", 32'(sw_addr), 32'd2);
        check("plain_valid_low", 32'(tx_valid), 32'd0);

        // Step 3: random backpressure, plus a start pulse while busy.
        launch();
        run_scan(1'b1, 1'b1);
        expect_full_scan();
        compare_stream("backpressure");
        check("bp_busy_low", 32'(busy), 32'd0);

        // Step 4: abort while byte 3 of frame 1 is held by tx_ready=0.
        tx_ready = 1'b1;
        launch();
        ok = 1'b0;
        for (int c = 0; c < 300 && !ok; c++) begin
            if (got_q.size() - got_base >= 8) begin
                tx_ready = 1'b0;
                ok = 1'b1;
            end else begin
                tick();
            end
        end
        check("abort_reach_byte", 32'(ok), 32'd1);
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            if (tx_valid) ok = 1'b1;
            else tick();
        end
        check("abort_byte_shown", 32'(ok), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        tick();
        check("abort_held_valid", 32'(tx_valid), 32'd1);
        check("abort_held_byte", 32'(tx_byte), 32'h11);
        check("abort_still_busy", 32'(busy), 32'd1);
        tx_ready = 1'b1;
        run_scan(1'b0, 1'b0);
        push_frame(0, 5);
        push_frame(1, 4);
        compare_stream("abort");
        repeat (4) tick();
        check("abort_no_more", 32'(got_q.size() - got_base), 32'd9);
        check("abort_busy_low", 32'(busy), 32'd0);

        // Step 5: asynchronous reset in the middle of SEND.
        tx_ready = 1'b0;
        launch();
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            if (tx_valid) ok = 1'b1;
            else tick();
        end
        check("rst_mid_reach_send", 32'(ok), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid_valid", 32'(tx_valid), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_addr", 32'(sw_addr), 32'd0);
        check("rst_mid_fsm", 32'(scan_state), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        tx_ready = 1'b1;
        launch();
        run_scan(1'b0, 1'b0);
        expect_full_scan();
        compare_stream("after_rst");

        // Step 6: abort alone in IDLE, then start and abort in the same cycle.
        abort = 1'b1;
        tick();
        tick();
        check("idle_abort_busy", 32'(busy), 32'd0);
        check("idle_abort_fsm", 32'(scan_state), 32'd0);
        launch();
        abort = 1'b0;
        run_scan(1'b0, 1'b0);
        expect_full_scan();
        compare_stream("start_abort");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
